// File: rtl/ctrl_pkg.sv
// Shared types for the control unit: FSM state encoding, opcodes, ALU selects
// and the bundled strobe/address output word with its Moore decoder.
package ctrl_pkg;

   typedef enum logic [3:0] {
      ST_INIT   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_NOOP   = 4'd3,
      ST_LOAD_A = 4'd4,
      ST_LOAD_B = 4'd5,
      ST_STORE  = 4'd6,
      ST_ADD    = 4'd7,
      ST_SUB    = 4'd8,
      ST_HALT   = 4'd9
   } state_t;

   localparam logic [3:0] OP_NOOP  = 4'b0000;
   localparam logic [3:0] OP_STORE = 4'b0001;
   localparam logic [3:0] OP_LOAD  = 4'b0010;
   localparam logic [3:0] OP_ADD   = 4'b0011;
   localparam logic [3:0] OP_SUB   = 4'b0100;
   localparam logic [3:0] OP_HALT  = 4'b0101;

   localparam logic [2:0] ALU_PASS = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;

   typedef struct packed {
      logic       pc_up;
      logic       pc_clr;
      logic       ir_ld;
      logic [7:0] d_addr;
      logic       d_wr;
      logic       rf_s;
      logic [3:0] rf_w_addr;
      logic [3:0] rf_ra_addr;
      logic [3:0] rf_rb_addr;
      logic       rf_w_en;
      logic [2:0] alu_s;
   } ctrl_out_t;

   function automatic state_t opcode_to_state(input logic [3:0] op);
      state_t st;
      case (op)
         OP_STORE: st = ST_STORE;
         OP_LOAD:  st = ST_LOAD_A;
         OP_ADD:   st = ST_ADD;
         OP_SUB:   st = ST_SUB;
         OP_HALT:  st = ST_HALT;
         default:  st = ST_NOOP;
      endcase
      return st;
   endfunction

   function automatic ctrl_out_t decode_outputs(input state_t st, input logic [15:0] ir);
      ctrl_out_t o;
      o = '0;
      o.alu_s = ALU_PASS;
      case (st)
         ST_INIT: o.pc_clr = 1'b1;
         ST_FETCH: begin
            o.ir_ld = 1'b1;
            o.pc_up = 1'b1;
         end
         ST_LOAD_A, ST_LOAD_B: begin
            o.d_addr    = ir[7:0];
            o.rf_s      = 1'b1;
            o.rf_w_addr = ir[11:8];
            o.rf_w_en   = (st == ST_LOAD_B);
         end
         ST_STORE: begin
            o.d_addr     = ir[7:0];
            o.rf_ra_addr = ir[11:8];
            o.d_wr       = 1'b1;
         end
         ST_ADD, ST_SUB: begin
            o.rf_ra_addr = ir[11:8];
            o.rf_rb_addr = ir[7:4];
            o.rf_w_addr  = ir[3:0];
            o.rf_w_en    = 1'b1;
            o.alu_s      = (st == ST_ADD) ? ALU_ADD : ALU_SUB;
         end
         default: o = '0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/instr_reg.sv
// 16-bit instruction register: synchronous clear wins over load, otherwise holds.
module instr_reg (
   input  logic        clk,
   input  logic        clear,
   input  logic        ld,
   input  logic [15:0] d,
   output logic [15:0] q
);

   logic [15:0] q_r;

   // instruction storage
   always_ff @(posedge clk) begin
      if (clear) begin
         q_r <= 16'h0000;
      end else if (ld) begin
         q_r <= d;
      end else begin
         q_r <= q_r;
      end
   end

   assign q = q_r;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM: fetch, decode and execute NOOP/LOAD/STORE/ADD/SUB/HALT.
// Outputs are registered from the state and IR value the coming edge will produce.
module control_unit
   import ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        clear,
   input  logic [15:0] ir_in,
   output logic        pc_up,
   output logic        pc_clr,
   output logic        ir_ld,
   output logic [7:0]  d_addr,
   output logic        d_wr,
   output logic        rf_s,
   output logic [3:0]  rf_w_addr,
   output logic [3:0]  rf_ra_addr,
   output logic [3:0]  rf_rb_addr,
   output logic        rf_w_en,
   output logic [2:0]  alu_s,
   output logic [3:0]  state
);

   state_t      state_r;
   state_t      state_next_s;
   logic        ir_ld_s;
   logic [15:0] ir_q_s;
   logic [15:0] ir_next_s;
   ctrl_out_t   out_next_s;
   ctrl_out_t   out_r;

   instr_reg u_ir (
      .clk   (clk),
      .clear (clear),
      .ld    (ir_ld_s),
      .d     (ir_in),
      .q     (ir_q_s)
   );

   // next-state selection and IR load strobe
   always_comb begin
      state_next_s = ST_INIT;
      ir_ld_s      = 1'b0;
      case (state_r)
         ST_INIT:   state_next_s = ST_FETCH;
         ST_FETCH: begin
            state_next_s = ST_DECODE;
            ir_ld_s      = 1'b1;
         end
         ST_DECODE: state_next_s = opcode_to_state(ir_q_s[15:12]);
         ST_LOAD_A: state_next_s = ST_LOAD_B;
         ST_NOOP, ST_LOAD_B, ST_STORE, ST_ADD, ST_SUB: state_next_s = ST_FETCH;
         ST_HALT:   state_next_s = ST_HALT;
         default:   state_next_s = ST_INIT;
      endcase
   end

   // IR contents after the coming edge, so outputs can be registered in step with the state
   always_comb begin
      ir_next_s = ir_q_s;
      if (clear) begin
         ir_next_s = 16'h0000;
      end else if (ir_ld_s) begin
         ir_next_s = ir_in;
      end else begin
         ir_next_s = ir_q_s;
      end
      out_next_s = decode_outputs(state_next_s, ir_next_s);
   end

   // state and output registers; clear overrides every transition
   always_ff @(posedge clk) begin
      if (clear) begin
         state_r <= ST_INIT;
         out_r   <= decode_outputs(ST_INIT, 16'h0000);
      end else begin
         state_r <= state_next_s;
         out_r   <= out_next_s;
      end
   end

   assign pc_up      = out_r.pc_up;
   assign pc_clr     = out_r.pc_clr;
   assign ir_ld      = out_r.ir_ld;
   assign d_addr     = out_r.d_addr;
   assign d_wr       = out_r.d_wr;
   assign rf_s       = out_r.rf_s;
   assign rf_w_addr  = out_r.rf_w_addr;
   assign rf_ra_addr = out_r.rf_ra_addr;
   assign rf_rb_addr = out_r.rf_rb_addr;
   assign rf_w_en    = out_r.rf_w_en;
   assign alu_s      = out_r.alu_s;
   assign state      = state_r;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench: a program memory plus PC model feeds ir_in; an instruction-level
// model expands each fetched instruction into its expected per-cycle output trace.
module tb_control_unit;
   import ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        clear;
   logic [15:0] ir_in;
   logic        pc_up, pc_clr, ir_ld, d_wr, rf_s, rf_w_en;
   logic [7:0]  d_addr;
   logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr, state;
   logic [2:0]  alu_s;

   always #5 clk = ~clk;

   control_unit dut (
      .clk(clk), .clear(clear), .ir_in(ir_in),
      .pc_up(pc_up), .pc_clr(pc_clr), .ir_ld(ir_ld),
      .d_addr(d_addr), .d_wr(d_wr), .rf_s(rf_s),
      .rf_w_addr(rf_w_addr), .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
      .rf_w_en(rf_w_en), .alu_s(alu_s), .state(state)
   );

   // program memory and a 7-bit PC driven by the DUT's requests
   logic [15:0] mem [0:127];
   logic [6:0]  env_pc = 7'd0;
   always @(posedge clk) begin
      if (pc_clr === 1'b1) env_pc <= 7'd0;
      else if (pc_up === 1'b1) env_pc <= env_pc + 7'd1;
   end
   assign ir_in = mem[env_pc];

   int vectors = 0;
   int miscompares = 0;
   logic [32:0] exp_q [$];
   int m_pc;
   bit m_halted;

   function automatic logic [32:0] mk(logic [3:0] st, logic up, logic clr, logic ld,
                                      logic [7:0] da, logic wr, logic s, logic [3:0] wa,
                                      logic [3:0] ra, logic [3:0] rb, logic wen, logic [2:0] alu);
      return {st, up, clr, ld, da, wr, s, wa, ra, rb, wen, alu};
   endfunction

   function automatic logic [32:0] act();
      return {state, pc_up, pc_clr, ir_ld, d_addr, d_wr, rf_s,
              rf_w_addr, rf_ra_addr, rf_rb_addr, rf_w_en, alu_s};
   endfunction

   // expand the next instruction of the program into its expected cycles
   task automatic model_fill();
      logic [15:0] ir;
      if (m_halted) begin
         exp_q.push_back(mk(ST_HALT, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0));
      end else begin
         ir = mem[m_pc];
         m_pc = (m_pc + 1) % 128;
         exp_q.push_back(mk(ST_FETCH, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0));
         exp_q.push_back(mk(ST_DECODE, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0));
         case (ir[15:12])
            4'h1: exp_q.push_back(mk(ST_STORE, 1'b0, 1'b0, 1'b0, ir[7:0], 1'b1, 1'b0, 4'h0, ir[11:8], 4'h0, 1'b0, 3'd0));
            4'h2: begin
               exp_q.push_back(mk(ST_LOAD_A, 1'b0, 1'b0, 1'b0, ir[7:0], 1'b0, 1'b1, ir[11:8], 4'h0, 4'h0, 1'b0, 3'd0));
               exp_q.push_back(mk(ST_LOAD_B, 1'b0, 1'b0, 1'b0, ir[7:0], 1'b0, 1'b1, ir[11:8], 4'h0, 4'h0, 1'b1, 3'd0));
            end
            4'h3: exp_q.push_back(mk(ST_ADD, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, ir[3:0], ir[11:8], ir[7:4], 1'b1, 3'd1));
            4'h4: exp_q.push_back(mk(ST_SUB, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, ir[3:0], ir[11:8], ir[7:4], 1'b1, 3'd2));
            4'h5: begin
               m_halted = 1'b1;
               exp_q.push_back(mk(ST_HALT, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0));
            end
            default: exp_q.push_back(mk(ST_NOOP, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0));
         endcase
      end
   endtask

   task automatic next_exp(output logic [32:0] e);
      if (exp_q.size() == 0) model_fill();
      e = exp_q.pop_front();
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // hold clear for n edges, release it, and restart the model at INIT
   task automatic apply_clear(int n);
      clear = 1'b1;
      repeat (n) tick();
      clear = 1'b0;
      exp_q.delete();
      m_pc = 0;
      m_halted = 1'b0;
      exp_q.push_back(mk(ST_INIT, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0));
   endtask

   task automatic fill_noop();
      for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
   endtask

   task automatic test_reset();
      logic [32:0] e;
      fill_noop();
      apply_clear(2);
      vectors++;
      if (state !== 4'(ST_INIT) || pc_clr !== 1'b1 || act() !== 33'({4'(ST_INIT), 3'b010, 26'd0})) begin
         miscompares++;
         $display("FAIL reset_init: got %h expected state 0 with pc_clr only", act());
      end
      for (int i = 0; i < 6; i++) begin
         next_exp(e);
         vectors++;
         if (act() !== e) begin
            miscompares++;
            $display("FAIL reset_seq cyc %0d: got %h expected %h", i, act(), e);
         end
         tick();
      end
   endtask

   task automatic test_program(string tag, int ncyc);
      logic [32:0] e;
      apply_clear(2);
      for (int i = 0; i < ncyc; i++) begin
         if (i > 0) tick();
         next_exp(e);
         vectors++;
         if (act() !== e) begin
            miscompares++;
            $display("FAIL %s cyc %0d: got %h expected %h", tag, i, act(), e);
         end
      end
   endtask

   task automatic test_directed();
      fill_noop();
      mem[0] = 16'h2A1B;
      mem[1] = 16'h1305;
      mem[2] = 16'h3124;
      mem[3] = 16'h4124;
      mem[4] = 16'hF000;
      mem[5] = 16'h6ABC;
      test_program("directed", 22);
   endtask

   task automatic test_halt();
      logic [32:0] e;
      fill_noop();
      mem[0] = 16'h0000;
      mem[1] = 16'h5000;
      apply_clear(2);
      for (int i = 0; i < 28; i++) begin
         if (i > 0) tick();
         next_exp(e);
         vectors++;
         if (act() !== e) begin
            miscompares++;
            $display("FAIL halt cyc %0d: got %h expected %h", i, act(), e);
         end
      end
      vectors++;
      if (env_pc !== 7'd2) begin
         miscompares++;
         $display("FAIL halt_pc: got %0d expected 2", env_pc);
      end
      apply_clear(1);
      vectors++;
      if (state !== 4'(ST_INIT) || pc_clr !== 1'b1) begin
         miscompares++;
         $display("FAIL halt_clear: got state %0d pc_clr %b expected 0 1", state, pc_clr);
      end
   endtask

   task automatic test_clear_mid_load();
      logic [32:0] e;
      bit wen_seen;
      fill_noop();
      mem[0] = 16'h2A1B;
      wen_seen = 1'b0;
      apply_clear(2);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         next_exp(e);
         vectors++;
         if (act() !== e) begin
            miscompares++;
            $display("FAIL midload cyc %0d: got %h expected %h", i, act(), e);
         end
         if (rf_w_en === 1'b1) wen_seen = 1'b1;
      end
      clear = 1'b1;
      tick();
      if (rf_w_en === 1'b1) wen_seen = 1'b1;
      vectors++;
      if (state !== 4'(ST_INIT) || pc_clr !== 1'b1 || wen_seen) begin
         miscompares++;
         $display("FAIL midload_clear: got state %0d pc_clr %b wen_seen %b expected 0 1 0",
                  state, pc_clr, wen_seen);
      end
      clear = 1'b0;
   endtask

   task automatic test_random_wrap();
      logic [15:0] w;
      for (int i = 0; i < 128; i++) begin
         w = 16'($urandom);
         if (w[15:12] == 4'h5) w[15:12] = 4'h3;
         mem[i] = w;
      end
      test_program("random_wrap", 900);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
         test_program("back_to_back", 20 + int'($urandom_range(0, 60)));
      end
   endtask

   initial begin
      clear = 1'b1;
      fill_noop();
      test_reset();
      test_directed();
      test_halt();
      test_clear_mid_load();
      test_random_wrap();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 clear  in  1  synchronous active-high reset; sampled on posedge clk.
REQ-004 ir_in  in  16  instruction-memory read data for the current PC address.
REQ-005 pc_up  out  1  increment request to the program counter.
REQ-006 pc_clr  out  1  clear request to the program counter.
REQ-007 ir_ld  out  1  instruction-register load strobe (debug visibility).
REQ-008 d_addr  out  8  data-memory address.
REQ-009 d_wr  out  1  data-memory write enable.
REQ-010 rf_s  out  1  register-file write-data mux select: 1 = data memory, 0 = ALU.
REQ-011 rf_w_addr, rf_ra_addr, rf_rb_addr  out  4 each  register-file write, read-A and read-B addresses.
REQ-012 rf_w_en  out  1  register-file write enable.
REQ-013 alu_s  out  3  ALU function select.
REQ-014 state  out  4  current FSM state encoding (debug/display).

Function
REQ-015 Instruction format: [15:12] opcode; LOAD [11:8] rd, [7:0] d_addr; STORE [11:8] ra, [7:0] d_addr; ADD/SUB [11:8] ra, [7:4] rb, [3:0] rd.
REQ-016 Opcodes: NOOP 0000, STORE 0001, LOAD 0010, ADD 0011, SUB 0100, HALT 0101; all other opcodes execute as NOOP.
REQ-017 States: INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT. Moore outputs, decoded from the state and the internal IR only.
REQ-018 INIT: pc_clr=1. Next state is FETCH.
REQ-019 FETCH: ir_ld=1 and pc_up=1. The IR captures ir_in and the PC increments on the same edge. Next state is DECODE.
REQ-020 DECODE: all strobes 0. Next state is selected by IR[15:12] per REQ-016.
REQ-021 NOOP: all strobes 0. Next state is FETCH.
REQ-022 LOAD_A: d_addr=IR[7:0], rf_s=1, rf_w_addr=IR[11:8], rf_w_en=0. Next state is LOAD_B.
REQ-023 LOAD_B: same as LOAD_A except rf_w_en=1. Next state is FETCH.
REQ-024 STORE: d_addr=IR[7:0], rf_ra_addr=IR[11:8], d_wr=1. Next state is FETCH.
REQ-025 ADD/SUB: rf_ra_addr=IR[11:8], rf_rb_addr=IR[7:4], rf_w_addr=IR[3:0], rf_s=0, rf_w_en=1; alu_s=ADD (3'd1) or SUB (3'd2). Next state is FETCH.
REQ-026 HALT: all strobes 0. Remains in HALT until clear.
REQ-027 Outside their active states, strobes are 0, alu_s=PASS (3'd0), and address outputs are 0.
REQ-028 Instruction cycle latency: NOOP, STORE, ADD and SUB take 3 clocks; LOAD takes 4 clocks. No PC increment occurs outside FETCH.
REQ-029 PC wrap (127 -> 0) is transparent; the unit keeps fetching normally.

Reset
REQ-030 clear=1 at a posedge forces state=INIT and IR=16'h0000 from any state, including mid-LOAD and HALT.
REQ-031 While in INIT after reset, pc_clr=1 and every other output is 0.
REQ-032 Reset has priority over all transitions and IR loads in the same cycle.

Structure
REQ-033 Package ctrl_pkg holds: the state enum (4-bit); opcode constants; ALU select constants (PASS=0, ADD=1, SUB=2).
REQ-034 Sub-module instr_reg: 16-bit register with clk, clear, ld, d, q. It loads on ld, clears on clear, and holds otherwise.

Verification
REQ-035 clear=1 for 2 cycles, then 0 -> state INIT with pc_clr=1 for 1 cycle, then FETCH with ir_ld=1 and pc_up=1.
REQ-036 ir_in=16'h2A1B (LOAD) -> LOAD_A with d_addr=8'h1B, rf_w_addr=4'hA, rf_s=1, rf_w_en=0; then LOAD_B with rf_w_en=1; then FETCH.
REQ-037 ir_in=16'h1305 (STORE) -> STORE with d_addr=8'h05, rf_ra_addr=4'h3, d_wr=1 for exactly 1 cycle.
REQ-038 ir_in=16'h3124 and then 16'h4124 -> ADD (alu_s=1) and then SUB (alu_s=2), each with ra=1, rb=2, rd=4, rf_w_en=1 for 1 cycle.
REQ-039 ir_in=16'h5000 -> HALT held for 20 cycles with pc_up=0; then clear=1 -> INIT.
REQ-040 ir_in=16'hF000 -> NOOP path, no strobes asserted. Separately, clear asserted in LOAD_A -> INIT next cycle, and rf_w_en is never asserted.
